control_word_sequencer: RTL

CONTROL_WORD_SEQUENCER -- requirements
Module: control_word_sequencer

---
 rtl/datapath_pkg.sv | 21 ++
 rtl/cw_program_mem.sv | 33 +++
 rtl/control_word_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the control-word sequencer datapath.
//   CW_W_DEF / DATA_W_DEF : default control-word and constant widths
//   STAT_V/C/N/Z          : bit positions of the datapath status flags
//   seq_state_t           : sequencer state encoding
package datapath_pkg;

    localparam int CW_W_DEF   = 25;
    localparam int DATA_W_DEF = 64;

    localparam int STAT_V = 3;
    localparam int STAT_C = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cw_program_mem.sv
// Program store for the sequencer: DEPTH entries of WIDTH bits.
// Write is synchronous, read is asynchronous. There is no reset, so the
// program survives a sequencer reset.
//   clock : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module cw_program_mem #(
    parameter  int WIDTH = 89,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/control_word_sequencer.sv
// Steps through a stored program of {control word, constant} entries and
// presents one entry per cycle to the datapath. A run covers entries
// 0..last_addr, repeated loop_count+1 times, and aborts early when any
// status flag selected by halt_mask is set.
//   clock, reset          : clock, synchronous active-high reset
//   prog_we/addr/cw/const : program write port (honoured in IDLE only)
//   start                 : begin a run (honoured in IDLE only)
//   last_addr, loop_count : run shape, latched at start
//   halt_mask             : abort mask, latched at start
//   status                : datapath flags {V,C,N,Z}
//   cw_out, const_out     : current entry, zero outside RUN
//   busy, done, halted    : run active, one-cycle end pulse, sticky abort
//   pc                    : index of the entry on cw_out
//
// state    | meaning
// ---------+------------------------------------------------------
// SEQ_IDLE | waiting for start; program memory writable
// SEQ_RUN  | emitting entry[pc] each cycle
// SEQ_DONE | one-cycle done pulse, then back to IDLE
module control_word_sequencer
    import datapath_pkg::*;
#(
    parameter  int CW_W   = CW_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [CW_W-1:0]   prog_cw,
    input  logic [DATA_W-1:0] prog_const,
    input  logic              start,
    input  logic [AW-1:0]     last_addr,
    input  logic [7:0]        loop_count,
    input  logic [3:0]        halt_mask,
    input  logic [3:0]        status,
    output logic [CW_W-1:0]   cw_out,
    output logic [DATA_W-1:0] const_out,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic [AW-1:0]     pc
);

    seq_state_t        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [AW-1:0]     last_q, last_d;
    logic [7:0]        pass_q, pass_d;
    logic [7:0]        loop_q, loop_d;
    logic [3:0]        mask_q, mask_d;
    logic              halted_q, halted_d;
    logic              mem_we;
    logic [CW_W+DATA_W-1:0] rd_entry;

    cw_program_mem #(
        .WIDTH (CW_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata ({prog_cw, prog_const}),
        .raddr (pc_q),
        .rdata (rd_entry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= SEQ_IDLE;
            pc_q     <= '0;
            last_q   <= '0;
            pass_q   <= '0;
            loop_q   <= '0;
            mask_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            last_q   <= last_d;
            pass_q   <= pass_d;
            loop_q   <= loop_d;
            mask_q   <= mask_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        last_d    = last_q;
        pass_d    = pass_q;
        loop_d    = loop_q;
        mask_d    = mask_q;
        halted_d  = halted_q;
        mem_we    = 1'b0;
        cw_out    = '0;
        const_out = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    // a write presented together with start is dropped
                    state_d  = SEQ_RUN;
                    pc_d     = '0;
                    pass_d   = '0;
                    last_d   = last_addr;
                    loop_d   = loop_count;
                    mask_d   = halt_mask;
                    halted_d = 1'b0;
                end else begin
                    // reset also blocks the write so it wins over prog_we
                    mem_we = prog_we && !reset;
                end
            end
            SEQ_RUN: begin
                busy      = 1'b1;
                cw_out    = rd_entry[CW_W+DATA_W-1:DATA_W];
                const_out = rd_entry[DATA_W-1:0];
                if ((status & mask_q) != 4'b0000) begin
                    state_d  = SEQ_DONE;
                    halted_d = 1'b1;
                end else if (pc_q != last_q) begin
                    pc_d = pc_q + 1'b1;
                end else if (pass_q != loop_q) begin
                    pc_d   = '0;
                    pass_d = pass_q + 8'd1;
                end else begin
                    state_d = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                done    = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    assign halted = halted_q;
    assign pc     = pc_q;

endmodule
